// File: rtl/scalar_reg_file_p_pkg.sv
// ---------------------------------------------------------------------------
// scalar_pkg
// Shared definitions for the scalar register file of the vector ASIP decode
// stage:
//   - sca_op_e    : 3-bit scalar op codes carried in the decoder's op field
//   - SCA_OP_W    : width of the op field
//   - *_DEF       : default WOM pointer window (first, last, stride)
//   - op_uses_idx : true for the ops that address an index counter
// No ports (package).
// ---------------------------------------------------------------------------
package scalar_pkg;

    localparam int SCA_OP_W = 3;

    typedef enum logic [SCA_OP_W-1:0] {
        SCA_INCR   = 3'b000,
        SCA_CLR    = 3'b001,
        SCA_SETN   = 3'b010,
        SCA_WOMADV = 3'b011,
        SCA_MULADV = 3'b100,
        SCA_NOP    = 3'b101,
        SCA_PTRRST = 3'b110,
        SCA_READ   = 3'b111
    } sca_op_e;

    localparam logic [31:0] WOM_FIRST_DEF  = 32'h0000_0000;
    localparam logic [31:0] WOM_LAST_DEF   = 32'h0000_03FC;
    localparam logic [31:0] WOM_STRIDE_DEF = 32'h0000_0004;

    // INCR, CLR and SETN are the only ops whose idx_sel field is meaningful
    function automatic logic op_uses_idx(input sca_op_e op);
        return (op == SCA_INCR) || (op == SCA_CLR) || (op == SCA_SETN);
    endfunction

endpackage

// File: rtl/scalar_reg_file_p_if.sv
// ---------------------------------------------------------------------------
// scalar_reg_file_p_if
// Bundles the decoder-facing op inputs and the registered result outputs of
// scalar_reg_file_p.
//   master : decoder side   (drives op_valid/op/idx_sel/imm, reads results)
//   slave  : register file  (reads op fields, drives results)
// Signals:
//   op_valid, op, idx_sel, imm          : one scalar op per cycle
//   idx_out, lim_out, rd_valid          : READ snapshot of indices/limits
//   wom_addr_out, wom_valid             : WOM address pointer
//   mul_pos_out, mul_valid              : MUL write position
//   wrap_out                            : per-index wrap pulse
//   err_out                             : bad idx_sel pulse
// ---------------------------------------------------------------------------
interface scalar_reg_file_p_if
    import scalar_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_IDX   = 2,
    parameter int IDX_SEL_W = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1,
    parameter int MUL_W     = 1
) ();

    logic                        op_valid;
    sca_op_e                     op;
    logic [IDX_SEL_W-1:0]        idx_sel;
    logic [DATA_W-1:0]           imm;

    logic [NUM_IDX*DATA_W-1:0]   idx_out;
    logic [NUM_IDX*DATA_W-1:0]   lim_out;
    logic                        rd_valid;
    logic [DATA_W-1:0]           wom_addr_out;
    logic                        wom_valid;
    logic [MUL_W-1:0]            mul_pos_out;
    logic                        mul_valid;
    logic [NUM_IDX-1:0]          wrap_out;
    logic                        err_out;

    modport master (
        output op_valid, op, idx_sel, imm,
        input  idx_out, lim_out, rd_valid, wom_addr_out, wom_valid,
               mul_pos_out, mul_valid, wrap_out, err_out
    );

    modport slave (
        input  op_valid, op, idx_sel, imm,
        output idx_out, lim_out, rd_valid, wom_addr_out, wom_valid,
               mul_pos_out, mul_valid, wrap_out, err_out
    );

endinterface

// File: rtl/scalar_reg_file_p_idx_ctr.sv
// ---------------------------------------------------------------------------
// scalar_idx_ctr
// One loop-index counter with its programmable wrap limit.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (idx=0, lim=all-ones)
//   i_inc      : INCR addressed to this counter
//   i_clr      : CLR addressed to this counter
//   i_set      : SETN addressed to this counter (limit <= i_imm)
//   i_carry_in : carry from the next-lower counter, behaves like INCR
//   i_imm      : new limit value for SETN
//   o_idx      : current index value
//   o_lim      : current limit value
//   o_wrap     : combinational, high when this cycle's step wraps to 0
// ---------------------------------------------------------------------------
module scalar_idx_ctr #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic              i_clr,
    input  logic              i_set,
    input  logic              i_carry_in,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_idx,
    output logic [DATA_W-1:0] o_lim,
    output logic              o_wrap
);

    logic [DATA_W-1:0] r_idx;
    logic [DATA_W-1:0] r_lim;
    logic              w_step;
    logic              w_at_lim;

    assign w_step   = i_inc | i_carry_in;
    assign w_at_lim = (r_idx == r_lim);
    assign o_wrap   = w_step & w_at_lim;
    assign o_idx    = r_idx;
    assign o_lim    = r_lim;

    // Equality (not >=) decides the wrap, so an index left above a freshly
    // lowered limit keeps counting until it rolls over modulo 2^DATA_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_lim <= '1;
        end else begin
            if (i_clr) begin
                r_idx <= '0;
            end else if (w_step) begin
                r_idx <= w_at_lim ? '0 : r_idx + DATA_W'(1);
            end
            if (i_set) begin
                r_lim <= i_imm;
            end
        end
    end

endmodule

// File: rtl/scalar_reg_file_p.sv
// ---------------------------------------------------------------------------
// scalar_reg_file_p
// Decode-stage scalar register block: NUM_IDX loop-index counters with wrap
// limits, a WOM address pointer (stride + wrap window) and a MUL write
// position selector. All results are registered, one cycle after the op.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, wins over op_valid
//   bus  : scalar_reg_file_p_if.slave (op inputs, registered outputs)
// Configuration macro:
//   SCALAR_IDX_CARRY_EN : a wrapping INCR on index k also steps index k+1,
//                         rippling upward; undefined keeps indices independent
// ---------------------------------------------------------------------------
module scalar_reg_file_p
    import scalar_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          NUM_IDX     = 2,
    parameter int          IDX_SEL_W   = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1,
    parameter logic [31:0] WOM_FIRST   = WOM_FIRST_DEF,
    parameter logic [31:0] WOM_LAST    = WOM_LAST_DEF,
    parameter logic [31:0] WOM_STRIDE  = WOM_STRIDE_DEF,
    parameter int          NUM_MUL_POS = 2,
    parameter int          MUL_W       = $clog2(NUM_MUL_POS)
) (
    input  logic               clk,
    input  logic               rst,
    scalar_reg_file_p_if.slave bus
);

    localparam logic [DATA_W-1:0] L_WOM_FIRST  = DATA_W'(WOM_FIRST);
    localparam logic [DATA_W-1:0] L_WOM_LAST   = DATA_W'(WOM_LAST);
    localparam logic [DATA_W-1:0] L_WOM_STRIDE = DATA_W'(WOM_STRIDE);
    localparam logic [MUL_W-1:0]  L_MUL_LAST   = MUL_W'(NUM_MUL_POS - 1);

    logic                      w_idx_op;
    logic                      w_sel_ok;
    logic                      w_err;
    logic [NUM_IDX-1:0]        w_inc;
    logic [NUM_IDX-1:0]        w_clr;
    logic [NUM_IDX-1:0]        w_set;
    logic [NUM_IDX-1:0]        w_carry;
    logic [NUM_IDX-1:0]        w_wrap;
    logic [NUM_IDX*DATA_W-1:0] w_idx_vec;
    logic [NUM_IDX*DATA_W-1:0] w_lim_vec;
    logic [DATA_W-1:0]         w_wom_next;
    logic [MUL_W-1:0]          w_mul_next;

    logic [NUM_IDX*DATA_W-1:0] r_idx_out;
    logic [NUM_IDX*DATA_W-1:0] r_lim_out;
    logic                      r_rd_valid;
    logic [DATA_W-1:0]         r_wom_addr;
    logic                      r_wom_on;
    logic                      r_wom_valid;
    logic [MUL_W-1:0]          r_mul_pos;
    logic                      r_mul_on;
    logic                      r_mul_valid;
    logic [NUM_IDX-1:0]        r_wrap;
    logic                      r_err;

    assign w_idx_op = bus.op_valid && op_uses_idx(bus.op);
    assign w_sel_ok = int'(bus.idx_sel) < NUM_IDX;
    assign w_err    = w_idx_op && !w_sel_ok;

    // Route INCR/CLR/SETN to the selected counter; an out-of-range select
    // reaches no counter at all.
    always_comb begin
        w_inc = '0;
        w_clr = '0;
        w_set = '0;
        for (int k = 0; k < NUM_IDX; k++) begin
            if (w_idx_op && w_sel_ok && (int'(bus.idx_sel) == k)) begin
                case (bus.op)
                    SCA_INCR: w_inc[k] = 1'b1;
                    SCA_CLR:  w_clr[k] = 1'b1;
                    SCA_SETN: w_set[k] = 1'b1;
                    default:  ;
                endcase
            end
        end
    end

`ifdef SCALAR_IDX_CARRY_EN
    // The carry chain is evaluated here from the registered index/limit
    // values so it never loops back through the counter instances. The top
    // index's wrap is simply not forwarded.
    always_comb begin
        logic v_c;
        v_c     = 1'b0;
        w_carry = '0;
        for (int k = 0; k < NUM_IDX; k++) begin
            w_carry[k] = v_c;
            v_c = (w_inc[k] | v_c) &&
                  (w_idx_vec[k*DATA_W +: DATA_W] == w_lim_vec[k*DATA_W +: DATA_W]);
        end
    end
`else
    assign w_carry = '0;
`endif

    for (genvar k = 0; k < NUM_IDX; k++) begin : g_idx
        scalar_idx_ctr #(.DATA_W(DATA_W)) u_ctr (
            .clk        (clk),
            .rst        (rst),
            .i_inc      (w_inc[k]),
            .i_clr      (w_clr[k]),
            .i_set      (w_set[k]),
            .i_carry_in (w_carry[k]),
            .i_imm      (bus.imm),
            .o_idx      (w_idx_vec[k*DATA_W +: DATA_W]),
            .o_lim      (w_lim_vec[k*DATA_W +: DATA_W]),
            .o_wrap     (w_wrap[k])
        );
    end

    // Pre-first state (r_wom_on/r_mul_on low) restarts at the first value
    // while the visible address/position keep their last issued value.
    always_comb begin
        w_wom_next = L_WOM_FIRST;
        if (r_wom_on && (r_wom_addr != L_WOM_LAST)) begin
            w_wom_next = r_wom_addr + L_WOM_STRIDE;
        end
        w_mul_next = '0;
        if (r_mul_on && (r_mul_pos != L_MUL_LAST)) begin
            w_mul_next = r_mul_pos + MUL_W'(1);
        end
    end

    // Output registers and pointers; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx_out   <= '0;
            r_lim_out   <= '0;
            r_rd_valid  <= 1'b0;
            r_wom_addr  <= '0;
            r_wom_on    <= 1'b0;
            r_wom_valid <= 1'b0;
            r_mul_pos   <= '0;
            r_mul_on    <= 1'b0;
            r_mul_valid <= 1'b0;
            r_wrap      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rd_valid  <= 1'b0;
            r_wom_valid <= 1'b0;
            r_mul_valid <= 1'b0;
            r_wrap      <= w_wrap;
            r_err       <= w_err;
            if (bus.op_valid) begin
                case (bus.op)
                    SCA_WOMADV: begin
                        r_wom_addr  <= w_wom_next;
                        r_wom_on    <= 1'b1;
                        r_wom_valid <= 1'b1;
                    end
                    SCA_MULADV: begin
                        r_mul_pos   <= w_mul_next;
                        r_mul_on    <= 1'b1;
                        r_mul_valid <= 1'b1;
                    end
                    SCA_PTRRST: begin
                        r_wom_on <= 1'b0;
                        r_mul_on <= 1'b0;
                    end
                    SCA_READ: begin
                        r_idx_out  <= w_idx_vec;
                        r_lim_out  <= w_lim_vec;
                        r_rd_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.idx_out      = r_idx_out;
    assign bus.lim_out      = r_lim_out;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.wom_addr_out = r_wom_addr;
    assign bus.wom_valid    = r_wom_valid;
    assign bus.mul_pos_out  = r_mul_pos;
    assign bus.mul_valid    = r_mul_valid;
    assign bus.wrap_out     = r_wrap;
    assign bus.err_out      = r_err;

endmodule

// File: tb/tb_scalar_reg_file_p.sv
// ---------------------------------------------------------------------------
// tb_scalar_reg_file_p
// Self-checking bench for scalar_reg_file_p with NUM_IDX=3, NUM_MUL_POS=3
// and a small WOM window (0..8 step 4). A behavioural model (arrays and
// plain arithmetic) tracks the expected state; directed scenarios are
// followed by a randomized op stream. Honours SCALAR_IDX_CARRY_EN.
// ---------------------------------------------------------------------------
module tb_scalar_reg_file_p;
    import scalar_pkg::*;

    localparam int          DW = 32;
    localparam int          NI = 3;
    localparam int          SW = 2;
    localparam int          NM = 3;
    localparam int          MW = 2;
    localparam logic [31:0] WF = 32'd0;
    localparam logic [31:0] WL = 32'd8;
    localparam logic [31:0] WS = 32'd4;
`ifdef SCALAR_IDX_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    scalar_reg_file_p_if #(.DATA_W(DW), .NUM_IDX(NI), .IDX_SEL_W(SW), .MUL_W(MW)) bus ();

    scalar_reg_file_p #(
        .DATA_W(DW), .NUM_IDX(NI), .IDX_SEL_W(SW), .WOM_FIRST(WF), .WOM_LAST(WL),
        .WOM_STRIDE(WS), .NUM_MUL_POS(NM), .MUL_W(MW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state and expected outputs
    logic [DW-1:0]    m_idx [NI];
    logic [DW-1:0]    m_lim [NI];
    logic [DW-1:0]    m_wom;
    bit               m_wom_on;
    int               m_mul;
    bit               m_mul_on;
    logic [NI*DW-1:0] e_idx_out;
    logic [NI*DW-1:0] e_lim_out;
    logic             e_rd;
    logic [DW-1:0]    e_wom_addr;
    logic             e_wom_v;
    logic [MW-1:0]    e_mul_pos;
    logic             e_mul_v;
    logic [NI-1:0]    e_wrap;
    logic             e_err;

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_idx[k] = '0;
            m_lim[k] = '1;
        end
        m_wom = '0; m_wom_on = 0; m_mul = 0; m_mul_on = 0;
        e_idx_out = '0; e_lim_out = '0; e_rd = 0; e_wom_addr = '0; e_wom_v = 0;
        e_mul_pos = '0; e_mul_v = 0; e_wrap = '0; e_err = 0;
    endtask

    task automatic model_step(input logic [2:0] o, input logic [1:0] s, input logic [DW-1:0] im);
        int k;
        bit go;
        e_rd = 0; e_wom_v = 0; e_mul_v = 0; e_wrap = '0; e_err = 0;
        if ((o <= 3'd2) && (int'(s) >= NI)) begin
            e_err = 1;
        end else begin
            case (o)
                3'd0: begin
                    k = int'(s); go = 1;
                    while (go) begin
                        go = 0;
                        if (m_idx[k] == m_lim[k]) begin
                            m_idx[k] = '0;
                            e_wrap[k] = 1'b1;
                            if (CARRY && (k < NI - 1)) begin k++; go = 1; end
                        end else begin
                            m_idx[k] = m_idx[k] + 1;
                        end
                    end
                end
                3'd1: m_idx[s] = '0;
                3'd2: m_lim[s] = im;
                3'd3: begin
                    m_wom = (!m_wom_on || m_wom == WL) ? WF : m_wom + WS;
                    m_wom_on = 1; e_wom_addr = m_wom; e_wom_v = 1;
                end
                3'd4: begin
                    m_mul = m_mul_on ? (m_mul + 1) % NM : 0;
                    m_mul_on = 1; e_mul_pos = MW'(m_mul); e_mul_v = 1;
                end
                3'd6: begin m_wom_on = 0; m_mul_on = 0; end
                3'd7: begin
                    for (int j = 0; j < NI; j++) begin
                        e_idx_out[j*DW +: DW] = m_idx[j];
                        e_lim_out[j*DW +: DW] = m_lim[j];
                    end
                    e_rd = 1;
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of inputs, update the model at the edge, sample after
    task automatic applyStimulus(input bit r, input bit v, input logic [2:0] o,
                                 input logic [1:0] s, input logic [DW-1:0] im);
        rst = r; bus.op_valid = v; bus.op = sca_op_e'(o); bus.idx_sel = s; bus.imm = im;
        @(posedge clk);
        if (r) model_reset();
        else if (v) model_step(o, s, im);
        else begin e_rd = 0; e_wom_v = 0; e_mul_v = 0; e_wrap = '0; e_err = 0; end
        #1;
        rst = 1'b0; bus.op_valid = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(1, 1, SCA_INCR, 0, 0);
        applyStimulus(1, 1, SCA_INCR, 0, 0);
        tests_run++;
        if ({bus.idx_out, bus.lim_out, bus.wom_addr_out, bus.mul_pos_out} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data got idx=%h lim=%h wom=%h mul=%h exp all 0",
                     bus.idx_out, bus.lim_out, bus.wom_addr_out, bus.mul_pos_out);
        end
        tests_run++;
        if ({bus.rd_valid, bus.wom_valid, bus.mul_valid, bus.wrap_out, bus.err_out} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_strobes got %b exp 0",
                     {bus.rd_valid, bus.wom_valid, bus.mul_valid, bus.wrap_out, bus.err_out});
        end
        applyStimulus(0, 1, SCA_READ, 0, 0);
        tests_run++;
        if (bus.rd_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_read_valid got %b exp 1", bus.rd_valid);
        end
        tests_run++;
        if (bus.idx_out !== {(NI*DW){1'b0}} || bus.lim_out !== {(NI*DW){1'b1}}) begin
            tests_failed++;
            $display("[TB] FAIL reset_read_values got idx=%h lim=%h exp idx=0 lim=all-ones",
                     bus.idx_out, bus.lim_out);
        end
        applyStimulus(0, 0, SCA_NOP, 0, 0);
        tests_run++;
        if (bus.rd_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read_pulse_width got %b exp 0", bus.rd_valid);
        end
    endtask

    task automatic test_setn_incr();
        logic [DW-1:0] seq  [4] = '{32'd1, 32'd2, 32'd0, 32'd1};
        logic [NI-1:0] wseq [4] = '{3'b000, 3'b000, 3'b010, 3'b000};
        applyStimulus(0, 1, SCA_SETN, 1, 32'd2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, SCA_INCR, 1, 0);
            tests_run++;
            if (bus.wrap_out !== wseq[i]) begin
                tests_failed++;
                $display("[TB] FAIL incr_wrap[%0d] got %b exp %b", i, bus.wrap_out, wseq[i]);
            end
            applyStimulus(0, 1, SCA_READ, 0, 0);
            tests_run++;
            if (bus.idx_out[DW +: DW] !== seq[i] || bus.lim_out[DW +: DW] !== 32'd2) begin
                tests_failed++;
                $display("[TB] FAIL incr_idx1[%0d] got idx=%0d lim=%0d exp idx=%0d lim=2",
                         i, bus.idx_out[DW +: DW], bus.lim_out[DW +: DW], seq[i]);
            end
        end
    endtask

    task automatic test_wom();
        logic [DW-1:0] seq [4] = '{32'd0, 32'd4, 32'd8, 32'd0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, SCA_WOMADV, 0, 0);
            tests_run++;
            if (bus.wom_addr_out !== seq[i] || bus.wom_valid !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL womadv[%0d] got addr=%0d valid=%b exp addr=%0d valid=1",
                         i, bus.wom_addr_out, bus.wom_valid, seq[i]);
            end
        end
        applyStimulus(0, 1, SCA_WOMADV, 0, 0);
        applyStimulus(0, 1, SCA_NOP, 0, 0);
        tests_run++;
        if (bus.wom_addr_out !== 32'd4 || bus.wom_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wom_hold got addr=%0d valid=%b exp addr=4 valid=0",
                     bus.wom_addr_out, bus.wom_valid);
        end
    endtask

    task automatic test_mul();
        logic [MW-1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, SCA_MULADV, 0, 0);
            tests_run++;
            if (bus.mul_pos_out !== seq[i] || bus.mul_valid !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL muladv[%0d] got pos=%0d valid=%b exp pos=%0d valid=1",
                         i, bus.mul_pos_out, bus.mul_valid, seq[i]);
            end
        end
        applyStimulus(0, 1, SCA_PTRRST, 0, 0);
        tests_run++;
        if (bus.mul_pos_out !== 2'd1 || {bus.mul_valid, bus.wom_valid} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL ptrrst got pos=%0d strobes=%b exp pos=1 strobes=00",
                     bus.mul_pos_out, {bus.mul_valid, bus.wom_valid});
        end
        applyStimulus(0, 1, SCA_MULADV, 0, 0);
        applyStimulus(0, 1, SCA_WOMADV, 0, 0);
        tests_run++;
        if (bus.mul_pos_out !== 2'd0 || bus.wom_addr_out !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL after_ptrrst got pos=%0d wom=%0d exp pos=0 wom=0",
                     bus.mul_pos_out, bus.wom_addr_out);
        end
    endtask

    task automatic test_carry();
        logic [DW-1:0] exp_j;
        exp_j = CARRY ? 32'd1 : 32'd0;
        applyStimulus(1, 0, SCA_NOP, 0, 0);
        applyStimulus(0, 1, SCA_SETN, 0, 32'd1);
        applyStimulus(0, 1, SCA_INCR, 0, 0);
        applyStimulus(0, 1, SCA_INCR, 0, 0);
        tests_run++;
        if (bus.wrap_out !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL carry_wrap got %b exp 001", bus.wrap_out);
        end
        applyStimulus(0, 1, SCA_READ, 0, 0);
        tests_run++;
        if (bus.idx_out[0 +: DW] !== 32'd0 || bus.idx_out[DW +: DW] !== exp_j) begin
            tests_failed++;
            $display("[TB] FAIL carry_idx got i=%0d j=%0d exp i=0 j=%0d",
                     bus.idx_out[0 +: DW], bus.idx_out[DW +: DW], exp_j);
        end
    endtask

    task automatic test_error();
        applyStimulus(1, 0, SCA_NOP, 0, 0);
        applyStimulus(0, 1, SCA_SETN, 3, 32'd5);
        tests_run++;
        if (bus.err_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_setn got %b exp 1", bus.err_out);
        end
        applyStimulus(0, 1, SCA_INCR, 3, 0);
        tests_run++;
        if (bus.err_out !== 1'b1 || bus.wrap_out !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL err_incr got err=%b wrap=%b exp err=1 wrap=000",
                     bus.err_out, bus.wrap_out);
        end
        applyStimulus(0, 1, SCA_CLR, 2, 0);
        tests_run++;
        if (bus.err_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_valid_sel got %b exp 0", bus.err_out);
        end
        applyStimulus(0, 1, SCA_READ, 0, 0);
        tests_run++;
        if (bus.idx_out !== {(NI*DW){1'b0}} || bus.lim_out !== {(NI*DW){1'b1}}) begin
            tests_failed++;
            $display("[TB] FAIL err_state got idx=%h lim=%h exp unchanged", bus.idx_out, bus.lim_out);
        end
    endtask

    task automatic test_random();
        bit            r, v;
        logic [2:0]    o;
        logic [1:0]    s;
        logic [DW-1:0] im;
        applyStimulus(1, 0, SCA_NOP, 0, 0);
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 7) != 0);
            o  = 3'($urandom_range(0, 7));
            s  = 2'($urandom_range(0, 3));
            im = ($urandom_range(0, 5) == 0) ? DW'($urandom) : DW'($urandom_range(0, 4));
            applyStimulus(r, v, o, s, im);
            tests_run++;
            if (bus.idx_out !== e_idx_out || bus.lim_out !== e_lim_out || bus.rd_valid !== e_rd) begin
                tests_failed++;
                $display("[TB] FAIL rnd_read[%0d] got idx=%h lim=%h rv=%b exp idx=%h lim=%h rv=%b",
                         n, bus.idx_out, bus.lim_out, bus.rd_valid, e_idx_out, e_lim_out, e_rd);
            end
            tests_run++;
            if (bus.wom_addr_out !== e_wom_addr || bus.wom_valid !== e_wom_v) begin
                tests_failed++;
                $display("[TB] FAIL rnd_wom[%0d] got %h/%b exp %h/%b",
                         n, bus.wom_addr_out, bus.wom_valid, e_wom_addr, e_wom_v);
            end
            tests_run++;
            if (bus.mul_pos_out !== e_mul_pos || bus.mul_valid !== e_mul_v) begin
                tests_failed++;
                $display("[TB] FAIL rnd_mul[%0d] got %0d/%b exp %0d/%b",
                         n, bus.mul_pos_out, bus.mul_valid, e_mul_pos, e_mul_v);
            end
            tests_run++;
            if (bus.wrap_out !== e_wrap || bus.err_out !== e_err) begin
                tests_failed++;
                $display("[TB] FAIL rnd_wrap_err[%0d] got wrap=%b err=%b exp wrap=%b err=%b",
                         n, bus.wrap_out, bus.err_out, e_wrap, e_err);
            end
        end
    endtask

    initial begin
        bus.op_valid = 1'b0; bus.op = SCA_NOP; bus.idx_sel = '0; bus.imm = '0;
        model_reset();
        test_reset();
        test_setn_incr();
        test_wom();
        test_mul();
        test_carry();
        test_error();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not complete in time");
        $fatal(1, "[TB] watchdog");
    end

endmodule
